// File: rtl/flash_shadow.sv
// flash_shadow: boot-time shadow copier.
//
// After reset, reads WORDS consecutive 16-bit words from flash (Wishbone
// master towards the flash controller) and writes each one to SRAM, holding
// the CPU in reset until the copy finishes. It then releases both buses and
// idles until the next reset.
//
// Parameters:
//   SRC_ADR  first flash word address (fm_adr_o space, wraps mod 2^17)
//   DST_ADR  first SRAM word address (sm_adr_o space, wraps mod 2^19)
//   WORDS    number of words to copy; 0 copies nothing
//
// Ports:
//   wb_clk_i, wb_rst_i           clock, async active-high reset
//   fm_adr_o/fm_dat_i            flash word address / read data
//   fm_cyc_o, fm_stb_o           flash cycle/strobe (read only)
//   fm_we_o, fm_tga_o            tied 0
//   fm_ack_i                     flash acknowledge (used only while reading)
//   sm_adr_o/sm_dat_o/sm_sel_o   SRAM word address / write data / selects
//   sm_we_o, sm_cyc_o, sm_stb_o  SRAM write/cycle/strobe
//   sm_ack_i                     SRAM acknowledge (used only while writing)
//   cpu_rst_o                    CPU reset hold, high until copy done
//   done_o                       copy complete
//   checksum_o                   (only with FLASH_SHADOW_CHECKSUM_EN) 16-bit
//                                running sum of every word read from flash
//
// Optional feature macro: FLASH_SHADOW_CHECKSUM_EN.

module flash_shadow #(
    parameter logic [16:0] SRC_ADR = 17'h0,
    parameter logic [18:0] DST_ADR = 19'h78000,
    parameter logic [16:0] WORDS   = 17'd32768
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    output logic [16:0] fm_adr_o,
    input  logic [15:0] fm_dat_i,
    output logic        fm_cyc_o,
    output logic        fm_stb_o,
    output logic        fm_we_o,
    output logic        fm_tga_o,
    input  logic        fm_ack_i,
    output logic [18:0] sm_adr_o,
    output logic [15:0] sm_dat_o,
    output logic [1:0]  sm_sel_o,
    output logic        sm_we_o,
    output logic        sm_cyc_o,
    output logic        sm_stb_o,
    input  logic        sm_ack_i,
    output logic        cpu_rst_o,
`ifdef FLASH_SHADOW_CHECKSUM_EN
    output logic [15:0] checksum_o,
`endif
    output logic        done_o
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state_q, state_d;
    logic [16:0] cnt_q, cnt_d;
    logic [15:0] dat_q, dat_d;

    // Next-cycle output values, decoded from the next state so the
    // registered outputs change on the same edge as the state does.
    logic        fm_act_d, sm_act_d;
    logic [16:0] fm_adr_d;
    logic [18:0] sm_adr_d;
    logic [15:0] sm_dat_d;

    assign fm_we_o  = 1'b0;
    assign fm_tga_o = 1'b0;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dat_d    = dat_q;
        case (state_q)
            IDLE: state_d = (WORDS == 17'd0) ? DONE : RD;
            RD: begin
                if (fm_ack_i) begin
                    dat_d   = fm_dat_i;
                    state_d = WR;
                end
            end
            // The flash trailing ack arrives here and is ignored because
            // only sm_ack_i is looked at in this state.
            WR: begin
                if (sm_ack_i) begin
                    if (cnt_q == WORDS - 17'd1) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 17'd1;
                        state_d = RD;
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        fm_act_d = (state_d == RD);
        sm_act_d = (state_d == WR);
        fm_adr_d = fm_act_d ? (SRC_ADR + cnt_d) : 17'd0;
        sm_adr_d = sm_act_d ? (DST_ADR + {2'b00, cnt_d}) : 19'd0;
        sm_dat_d = sm_act_d ? dat_d : 16'd0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            fm_cyc_o  <= 1'b0;
            fm_stb_o  <= 1'b0;
            fm_adr_o  <= '0;
            sm_cyc_o  <= 1'b0;
            sm_stb_o  <= 1'b0;
            sm_we_o   <= 1'b0;
            sm_sel_o  <= 2'b00;
            sm_adr_o  <= '0;
            sm_dat_o  <= '0;
            cpu_rst_o <= 1'b1;
            done_o    <= 1'b0;
        end else begin
            fm_cyc_o  <= fm_act_d;
            fm_stb_o  <= fm_act_d;
            fm_adr_o  <= fm_adr_d;
            sm_cyc_o  <= sm_act_d;
            sm_stb_o  <= sm_act_d;
            sm_we_o   <= sm_act_d;
            sm_sel_o  <= {2{sm_act_d}};
            sm_adr_o  <= sm_adr_d;
            sm_dat_o  <= sm_dat_d;
            cpu_rst_o <= (state_d != DONE);
            done_o    <= (state_d == DONE);
        end
    end

`ifdef FLASH_SHADOW_CHECKSUM_EN
    // Accumulate on the same edge the word is latched, so the sum is
    // complete by the time done_o rises.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            checksum_o <= '0;
        else if (state_q == RD && fm_ack_i)
            checksum_o <= checksum_o + fm_dat_i;
    end
`endif

endmodule

// File: tb/tb_flash_shadow.sv
module tb_flash_shadow;

    localparam int N = 3;
    localparam logic [16:0] SRC_T [N] = '{17'h100, 17'h1FFFE, 17'h0};
    localparam logic [18:0] DST_T [N] = '{19'h78000, 19'h7FFFF, 19'h78000};
    localparam int          WRD_T [N] = '{4, 3, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // per-word ack latencies (cycles from strobe to ack), shared by all DUTs
    int lf [8];
    int ls [8];
    int cyc;
    int total = 0;
    int bad = 0;
    int done_at [N];
    bit chk_en = 1'b0;

    logic [62:0] got [N];
    logic [15:0] csum [N];

    function automatic logic [15:0] fdat(input logic [16:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // Timeline model: word i occupies a read window of lf[i]+1 cycles then a
    // write window of ls[i]+1 cycles; the first read begins one edge after
    // release and done follows the last write window.
    function automatic logic [62:0] model(input int g, input int k);
        logic fc = 1'b0, sc = 1'b0, dn = 1'b0;
        logic [16:0] fa = '0;
        logic [18:0] sa = '0;
        logic [15:0] sd = '0;
        int st = 1;
        if (k > 0) begin
            for (int i = 0; i < WRD_T[g]; i++) begin
                int re = st + lf[i];
                int we = re + 1 + ls[i];
                if (k >= st && k <= re) begin
                    fc = 1'b1; fa = SRC_T[g] + 17'(i);
                end else if (k > re && k <= we) begin
                    sc = 1'b1; sa = DST_T[g] + 19'(i); sd = fdat(SRC_T[g] + 17'(i));
                end
                st = we + 1;
            end
            dn = (k >= st);
        end
        return {fc, fc, 1'b0, 1'b0, fa, sc, sc, sc, {2{sc}}, sa, sd, !dn, dn};
    endfunction

    function automatic logic [15:0] model_sum(input int g);
        logic [15:0] s = '0;
        for (int i = 0; i < WRD_T[g]; i++) s = s + fdat(SRC_T[g] + 17'(i));
        return s;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, a, e);
        end
    endtask

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_d
            logic fcyc, fstb, fwe, ftga, scyc, sstb, swe, crst, dn;
            logic [16:0] fadr;
            logic [15:0] fdin, sdat, cs;
            logic [18:0] sadr;
            logic [1:0]  ssel;
            logic fack, sack;
            int fcnt, scnt, fidx, sidx, wn, rn;
            logic [34:0] wlog [8];
            logic [16:0] rlog [8];

            assign fdin = fdat(fadr);

            flash_shadow #(.SRC_ADR(SRC_T[g]), .DST_ADR(DST_T[g]), .WORDS(17'(WRD_T[g]))) u_dut (
                .wb_clk_i(clk), .wb_rst_i(rst),
                .fm_adr_o(fadr), .fm_dat_i(fdin), .fm_cyc_o(fcyc), .fm_stb_o(fstb),
                .fm_we_o(fwe), .fm_tga_o(ftga), .fm_ack_i(fack),
                .sm_adr_o(sadr), .sm_dat_o(sdat), .sm_sel_o(ssel), .sm_we_o(swe),
                .sm_cyc_o(scyc), .sm_stb_o(sstb), .sm_ack_i(sack),
                .cpu_rst_o(crst),
`ifdef FLASH_SHADOW_CHECKSUM_EN
                .checksum_o(cs),
`endif
                .done_o(dn)
            );
`ifndef FLASH_SHADOW_CHECKSUM_EN
            assign cs = '0;
`endif
            assign got[g]  = {fcyc, fstb, fwe, ftga, fadr, scyc, sstb, swe, ssel, sadr, sdat, crst, dn};
            assign csum[g] = cs;

            // Responders: ack goes high lf/ls cycles after strobe and stays one
            // cycle past strobe dropping (trailing ack).
            always @(posedge clk or posedge rst) begin
                if (rst) begin
                    fcnt <= 0; scnt <= 0; fidx <= 0; sidx <= 0;
                    fack <= 1'b0; sack <= 1'b0; wn <= 0; rn <= 0;
                end else begin
                    fcnt <= fstb ? fcnt + 1 : 0;
                    fack <= fstb && (fcnt + 1 >= lf[fidx % 8]);
                    scnt <= sstb ? scnt + 1 : 0;
                    sack <= sstb && (scnt + 1 >= ls[sidx % 8]);
                    if (fstb && fack) begin
                        fidx <= fidx + 1;
                        if (rn < 8) begin rlog[rn] <= fadr; rn <= rn + 1; end
                    end
                    if (sstb && sack) begin
                        sidx <= sidx + 1;
                        if (wn < 8) begin wlog[wn] <= {sadr, sdat}; wn <= wn + 1; end
                    end
                end
            end
        end
    endgenerate

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Every-cycle comparison of all DUT outputs against the timeline model.
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("bus dut%0d cyc%0d", k, cyc), 64'(got[k]), 64'(model(k, cyc)));
                if (got[k][0] && done_at[k] < 0) begin
                    done_at[k] = cyc;
`ifdef FLASH_SHADOW_CHECKSUM_EN
                    chk($sformatf("checksum dut%0d", k), 64'(csum[k]), 64'(model_sum(k)));
`endif
                end
            end
        end
    end

    task automatic start_phase();
        for (int k = 0; k < N; k++) done_at[k] = -1;
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic wait_all();
        int n = 0;
        while (!(done_at[0] >= 0 && done_at[1] >= 0 && done_at[2] >= 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            total++; bad++;
            $display("FAIL done_timeout got=%0d,%0d,%0d exp=all_done", done_at[0], done_at[1], done_at[2]);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic set_lat(input bit rnd, input int a, input int b);
        for (int i = 0; i < 8; i++) begin
            lf[i] = rnd ? int'($urandom_range(4, 1)) : a;
            ls[i] = rnd ? int'($urandom_range(4, 1)) : b;
        end
    endtask

    initial begin
        int target, n;
        set_lat(1'b0, 1, 1);
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) chk($sformatf("reset dut%0d", k), 64'(got[k]), 64'(model(k, 0)));

        // Phase 0: single-cycle acks, hand-computed expectations
        start_phase();
        wait_all();
        chk("done_cyc dut0", 64'(done_at[0]), 64'd17);
        chk("done_cyc dut1", 64'(done_at[1]), 64'd13);
        chk("done_cyc dut2", 64'(done_at[2]), 64'd1);
        chk("wcount dut0", 64'(g_d[0].wn), 64'd4);
        chk("write0 dut0", 64'(g_d[0].wlog[0]), 64'({19'h78000, 16'hA4A5}));
        chk("write1 dut0", 64'(g_d[0].wlog[1]), 64'({19'h78001, 16'hA4A4}));
        chk("write2 dut0", 64'(g_d[0].wlog[2]), 64'({19'h78002, 16'hA4A7}));
        chk("write3 dut0", 64'(g_d[0].wlog[3]), 64'({19'h78003, 16'hA4A6}));
        chk("rcount dut1", 64'(g_d[1].rn), 64'd3);
        chk("read0 dut1", 64'(g_d[1].rlog[0]), 64'(17'h1FFFE));
        chk("read1 dut1", 64'(g_d[1].rlog[1]), 64'(17'h1FFFF));
        chk("read2 dut1", 64'(g_d[1].rlog[2]), 64'(17'h00000));
        chk("wadr1 dut1", 64'(g_d[1].wlog[1][34:16]), 64'(19'h00000));
        chk("traffic dut2", 64'(g_d[2].rn + g_d[2].wn), 64'd0);

        // Phase 1: random latencies, reset in the first write cycle of word 2
        @(negedge clk); rst = 1'b1; chk_en = 1'b0;
        set_lat(1'b1, 0, 0);
        repeat (2) @(negedge clk);
        start_phase();
        target = 1 + (lf[0] + ls[0] + 2) + lf[1] + 1;
        n = 0;
        while (cyc != target && n < 400) begin @(negedge clk); n++; end
        chk("reached_word2_wr", 64'(g_d[0].sstb), 64'd1);
        #2 rst = 1'b1; chk_en = 1'b0;
        #1;
        for (int k = 0; k < N; k++) chk($sformatf("midreset dut%0d", k), 64'(got[k]), 64'(model(k, 0)));
        repeat (2) @(negedge clk);

        // Phase 2: fresh random latencies, full copy after the abort
        set_lat(1'b1, 0, 0);
        start_phase();
        wait_all();
        chk("wcount2 dut0", 64'(g_d[0].wn), 64'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rewrite%0d dut0", i), 64'(g_d[0].wlog[i]),
                64'({DST_T[0] + 19'(i), fdat(SRC_T[0] + 17'(i))}));

        // Phase 3: flash ack 3 cycles, SRAM ack 2 cycles
        @(negedge clk); rst = 1'b1; chk_en = 1'b0;
        set_lat(1'b0, 3, 2);
        repeat (2) @(negedge clk);
        start_phase();
        wait_all();
        chk("done_cyc3 dut0", 64'(done_at[0]), 64'd29);
        chk("wcount3 dut0", 64'(g_d[0].wn), 64'd4);
        chk("write3 last dut0", 64'(g_d[0].wlog[3]), 64'({19'h78003, 16'hA4A6}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
